// File: rtl/bounce_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bounce_pkg
//  Description : Shared types and pulse encodings for the bounce counter and
//                the collision logic that consumes its bounce pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
package bounce_pkg;

  // Direction of travel along one axis.
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  // Bounce pulses packed as {hi, lo}; collision logic decodes the same bits.
  typedef logic [1:0] pulse_t;

  localparam int     c_pulse_lo_bit = 0;
  localparam int     c_pulse_hi_bit = 1;
  localparam pulse_t c_pulse_none   = 2'b00;
  localparam pulse_t c_pulse_lo     = 2'b01;
  localparam pulse_t c_pulse_hi     = 2'b10;

  // Pack the two bound-hit flags into the shared pulse encoding.
  function automatic pulse_t pulse_encode(input logic hit_lo, input logic hit_hi);
    return {hit_hi, hit_lo};
  endfunction

endpackage
`default_nettype wire

// File: rtl/bounce_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : bounce_counter_if
//  Description : Control/status bundle of one bounce counter axis. The master
//                side (game logic) drives moves, loads and bounds; the slave
//                side (the counter) returns position, direction and pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bounce_counter_if #(
  parameter int WIDTH  = 10,
  parameter int STEP_W = 4
);
  logic              en;
  logic              load;
  logic [WIDTH-1:0]  D;
  logic              load_up;
  logic              flip;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  low;
  logic [WIDTH-1:0]  high;
  logic [WIDTH-1:0]  Q;
  logic              up;
  logic              bounce_lo;
  logic              bounce_hi;
  logic              at_low;
  logic              at_high;
  logic [STEP_W-1:0] cur_step;

  modport master (
    output en, load, D, load_up, flip, step, low, high,
    input  Q, up, bounce_lo, bounce_hi, at_low, at_high, cur_step
  );

  modport slave (
    input  en, load, D, load_up, flip, step, low, high,
    output Q, up, bounce_lo, bounce_hi, at_low, at_high, cur_step
  );
endinterface
`default_nettype wire

// File: rtl/bounce_counter_next.sv
`default_nettype none
// ============================================================================
//  Module      : bounce_next
//  Description : Combinational next-position calculator. Applies one move of
//                cur_step in the given direction, clamping at the bounds and
//                flagging a reversal when a bound would be crossed. Sums are
//                carried in WIDTH+1 bits so nothing wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
module bounce_next
  import bounce_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  i_q,
  input  dir_t              i_dir,
  input  logic [STEP_W-1:0] i_cur_step,
  input  logic [WIDTH-1:0]  i_low,
  input  logic [WIDTH-1:0]  i_high,
  output logic [WIDTH-1:0]  o_q_next,
  output logic              o_reverse,
  output logic              o_hit_lo,
  output logic              o_hit_hi
);

  logic [WIDTH:0] w_q_ext;
  logic [WIDTH:0] w_step_ext;
  logic [WIDTH:0] w_low_ext;
  logic [WIDTH:0] w_high_ext;
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_floor;
  logic [WIDTH:0] w_diff;

  assign w_q_ext    = {1'b0, i_q};
  assign w_step_ext = (WIDTH+1)'(i_cur_step);
  assign w_low_ext  = {1'b0, i_low};
  assign w_high_ext = {1'b0, i_high};
  assign w_sum      = w_q_ext + w_step_ext;
  assign w_floor    = w_low_ext + w_step_ext;
  // Only meaningful when w_q_ext >= w_floor, which is checked before use.
  assign w_diff     = w_q_ext - w_step_ext;

  // One move: crossing a bound clamps and reverses; out-of-range positions
  // left behind by a bound change are pulled back without a pulse.
  always_comb begin
    o_q_next  = i_q;
    o_reverse = 1'b0;
    o_hit_lo  = 1'b0;
    o_hit_hi  = 1'b0;
    if ((i_low <= i_high) && (i_cur_step != '0)) begin
      if (i_dir == DIR_UP) begin
        if (w_sum > w_high_ext) begin
          o_q_next  = i_high;
          o_reverse = 1'b1;
          o_hit_hi  = 1'b1;
        end else if (w_sum < w_low_ext) begin
          o_q_next = i_low;
        end else begin
          o_q_next = w_sum[WIDTH-1:0];
        end
      end else begin
        if (w_q_ext < w_floor) begin
          o_q_next  = i_low;
          o_reverse = 1'b1;
          o_hit_lo  = 1'b1;
        end else if (w_diff > w_high_ext) begin
          o_q_next = i_high;
        end else begin
          o_q_next = w_diff[WIDTH-1:0];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bounce_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bounce_counter
//  Description : Bounded position counter with programmable step. Clamps at
//                runtime bounds, reverses direction there and emits one-cycle
//                bounce pulses. One instance per pong axis.
//                Optional macro BOUNCE_COUNTER_RAMP_EN adds a speed-up ramp
//                that grows the effective step on every bounce.
//  Revision    : 1.0 - initial release
// ============================================================================
module bounce_counter
  import bounce_pkg::*;
#(
  parameter int WIDTH     = 10,
  parameter int STEP_W    = 4,
  parameter int RESET_POS = 0,
  parameter int RAMP_MAX  = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  bounce_counter_if.slave  bus
);

  localparam int c_ramp_w = (RAMP_MAX > 1) ? $clog2(RAMP_MAX + 1) : 1;

  logic [WIDTH-1:0]  r_q;
  dir_t              r_up;
  pulse_t            r_pulse;

  logic [c_ramp_w-1:0] w_ramp;
  logic [STEP_W:0]     w_step_sum;
  logic [STEP_W-1:0]   w_cur_step;
  logic                w_bounds_ok;
  dir_t                w_dir_inv;
  dir_t                w_dir_eff;
  dir_t                w_dir_move;
  logic [WIDTH-1:0]    w_load_q;
  logic [WIDTH-1:0]    w_q_next;
  logic                w_reverse;
  logic                w_hit_lo;
  logic                w_hit_hi;

  assign w_bounds_ok = (bus.low <= bus.high);
  assign w_dir_inv   = (r_up == DIR_UP) ? DIR_DOWN : DIR_UP;
  // A flip request toggles direction before the move of the same cycle.
  assign w_dir_eff   = (w_bounds_ok && bus.flip) ? w_dir_inv : r_up;
  assign w_dir_move  = w_reverse ? ((w_dir_eff == DIR_UP) ? DIR_DOWN : DIR_UP)
                                 : w_dir_eff;

  // Load value clamped into the bounds; with inverted bounds park at low.
  always_comb begin
    w_load_q = bus.D;
    if (!w_bounds_ok || (bus.D < bus.low)) begin
      w_load_q = bus.low;
    end else if (bus.D > bus.high) begin
      w_load_q = bus.high;
    end
  end

`ifdef BOUNCE_COUNTER_RAMP_EN
  logic [c_ramp_w-1:0] r_ramp;

  // Speed-up ramp: one notch per bounce, saturating, cleared on load.
  always_ff @(posedge clk) begin
    if (!reset_n || bus.load) begin
      r_ramp <= '0;
    end else if (bus.en && (w_hit_lo || w_hit_hi) &&
                 (r_ramp != c_ramp_w'(RAMP_MAX))) begin
      r_ramp <= r_ramp + 1'b1;
    end
  end

  assign w_ramp = r_ramp;
`else
  assign w_ramp = '0;
`endif

  // Effective step is base step plus ramp, saturating at the step range.
  assign w_step_sum = (STEP_W+1)'(bus.step) + (STEP_W+1)'(w_ramp);
  assign w_cur_step = w_step_sum[STEP_W] ? '1 : w_step_sum[STEP_W-1:0];

  bounce_next #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_next (
    .i_q        (r_q),
    .i_dir      (w_dir_eff),
    .i_cur_step (w_cur_step),
    .i_low      (bus.low),
    .i_high     (bus.high),
    .o_q_next   (w_q_next),
    .o_reverse  (w_reverse),
    .o_hit_lo   (w_hit_lo),
    .o_hit_hi   (w_hit_hi)
  );

  // Position, direction and pulse registers: reset > load > flip/move.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_q     <= WIDTH'(RESET_POS);
      r_up    <= DIR_UP;
      r_pulse <= c_pulse_none;
    end else if (bus.load) begin
      r_q     <= w_load_q;
      r_up    <= bus.load_up ? DIR_UP : DIR_DOWN;
      r_pulse <= c_pulse_none;
    end else begin
      r_pulse <= c_pulse_none;
      if (w_bounds_ok) begin
        r_up <= w_dir_eff;
        if (bus.en) begin
          r_q     <= w_q_next;
          r_up    <= w_dir_move;
          r_pulse <= pulse_encode(w_hit_lo, w_hit_hi);
        end
      end
    end
  end

  assign bus.Q         = r_q;
  assign bus.up        = (r_up == DIR_UP);
  assign bus.bounce_lo = r_pulse[c_pulse_lo_bit];
  assign bus.bounce_hi = r_pulse[c_pulse_hi_bit];
  assign bus.at_low    = (r_q == bus.low);
  assign bus.at_high   = (r_q == bus.high);
  assign bus.cur_step  = w_cur_step;

endmodule
`default_nettype wire

// File: tb/tb_bounce_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bounce_counter
//  Description : Self-checking bench for bounce_counter: directed scenarios
//                followed by randomized traffic against an integer model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bounce_counter;
  localparam int WIDTH     = 10;
  localparam int STEP_W    = 4;
  localparam int RESET_POS = 0;
  localparam int RAMP_MAX  = 3;
  localparam int STEP_SAT  = (1 << STEP_W) - 1;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  bounce_counter_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();

  bounce_counter #(
    .WIDTH     (WIDTH),
    .STEP_W    (STEP_W),
    .RESET_POS (RESET_POS),
    .RAMP_MAX  (RAMP_MAX)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: position, direction, last pulses, ramp level.
  int m_q, m_up, m_lo, m_hi, m_ramp;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_tests++;
    if (got !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int rn, input int en, input int ld, input int d,
                       input int lu, input int fl, input int st,
                       input int lo, input int hi);
    reset_n     = rn[0];
    bus.en      = en[0];
    bus.load    = ld[0];
    bus.D       = WIDTH'(d);
    bus.load_up = lu[0];
    bus.flip    = fl[0];
    bus.step    = STEP_W'(st);
    bus.low     = WIDTH'(lo);
    bus.high    = WIDTH'(hi);
  endtask

  function automatic int eff_step();
    int s;
    s = int'(bus.step) + m_ramp;
    return (s > STEP_SAT) ? STEP_SAT : s;
  endfunction

  // Advance one clock, stepping the model from the currently driven inputs,
  // then compare every output.
  task automatic tick();
    int cs, lo, hi, dv, d, nq, nu, nlo, nhi, nr;
    cs = eff_step();
    lo = int'(bus.low);
    hi = int'(bus.high);
    dv = int'(bus.D);
    nq = m_q; nu = m_up; nlo = 0; nhi = 0; nr = m_ramp;
    if (!reset_n) begin
      nq = RESET_POS; nu = 1; nr = 0;
    end else if (bus.load) begin
      if (lo > hi || dv < lo) nq = lo;
      else if (dv > hi)       nq = hi;
      else                    nq = dv;
      nu = int'(bus.load_up);
      nr = 0;
    end else if (lo <= hi) begin
      d = bus.flip ? 1 - m_up : m_up;
      if (bus.en && cs > 0) begin
        if (d == 1) begin
          if (m_q + cs > hi) begin nq = hi; d = 0; nhi = 1; end
          else nq = (m_q + cs < lo) ? lo : m_q + cs;
        end else begin
          if (m_q - cs < lo) begin nq = lo; d = 1; nlo = 1; end
          else nq = (m_q - cs > hi) ? hi : m_q - cs;
        end
      end
      nu = d;
`ifdef BOUNCE_COUNTER_RAMP_EN
      if (bus.en && (nlo == 1 || nhi == 1)) nr = (m_ramp < RAMP_MAX) ? m_ramp + 1 : RAMP_MAX;
`endif
    end
    @(posedge clk);
    #1;
    m_q = nq; m_up = nu; m_lo = nlo; m_hi = nhi; m_ramp = nr;
    chk("q",        32'(bus.Q),         m_q);
    chk("up",       32'(bus.up),        m_up);
    chk("bnc_lo",   32'(bus.bounce_lo), m_lo);
    chk("bnc_hi",   32'(bus.bounce_hi), m_hi);
    chk("at_low",   32'(bus.at_low),    (m_q == int'(bus.low))  ? 1 : 0);
    chk("at_high",  32'(bus.at_high),   (m_q == int'(bus.high)) ? 1 : 0);
    chk("cur_step", 32'(bus.cur_step),  eff_step());
  endtask

  int lo_r, hi_r, st_r;
  int bounces, budget;

  initial begin
    m_q = 0; m_up = 1; m_lo = 0; m_hi = 0; m_ramp = 0;
    drive(0, 1, 0, 0, 0, 0, 4, 0, 0);

    // Reset held two cycles with en high.
    tick(); tick();
    chk("rst_q", 32'(bus.Q), 0);
    chk("rst_up", 32'(bus.up), 1);
    chk("rst_pulses", 32'({bus.bounce_hi, bus.bounce_lo}), 0);
    chk("rst_step", 32'(bus.cur_step), 4);

    // Upper bounce.
    drive(1, 0, 1, 95, 1, 0, 4, 10, 100); tick();
    chk("ub_load", 32'(bus.Q), 95);
    drive(1, 1, 0, 0, 0, 0, 4, 10, 100); tick();
    chk("ub_q1", 32'(bus.Q), 99);
    tick();
    chk("ub_q2", 32'(bus.Q), 100);
    chk("ub_up2", 32'(bus.up), 0);
    chk("ub_hi2", 32'(bus.bounce_hi), 1);
    tick();
`ifdef BOUNCE_COUNTER_RAMP_EN
    chk("ub_q3", 32'(bus.Q), 95);
`else
    chk("ub_q3", 32'(bus.Q), 96);
`endif
    chk("ub_hi3", 32'(bus.bounce_hi), 0);

    // No underflow below zero.
    drive(1, 0, 1, 3, 0, 0, 5, 0, 100); tick();
    drive(1, 1, 0, 0, 0, 0, 5, 0, 100); tick();
    chk("uf_q", 32'(bus.Q), 0);
    chk("uf_up", 32'(bus.up), 1);
    chk("uf_lo", 32'(bus.bounce_lo), 1);

    // Flip combined with a move.
    drive(1, 0, 1, 50, 1, 0, 2, 0, 100); tick();
    drive(1, 1, 0, 0, 0, 1, 2, 0, 100); tick();
    chk("flip_q", 32'(bus.Q), 48);
    chk("flip_up", 32'(bus.up), 0);
    chk("flip_pulse", 32'({bus.bounce_hi, bus.bounce_lo}), 0);

    // Load wins over en/flip and clamps to high.
    drive(1, 1, 1, 200, 0, 1, 2, 0, 100); tick();
    chk("ldp_q", 32'(bus.Q), 100);
    chk("ldp_up", 32'(bus.up), 0);

    // Landing exactly on a bound does not reverse; the next tick does.
    drive(1, 0, 1, 96, 1, 0, 4, 0, 100); tick();
    drive(1, 1, 0, 0, 0, 0, 4, 0, 100); tick();
    chk("exact_q", 32'(bus.Q), 100);
    chk("exact_up", 32'(bus.up), 1);
    chk("exact_hi", 32'(bus.bounce_hi), 0);
    tick();
    chk("cross_up", 32'(bus.up), 0);
    chk("cross_hi", 32'(bus.bounce_hi), 1);

    // step=0 leaves an out-of-range position alone.
    drive(1, 0, 1, 50, 1, 0, 0, 0, 100); tick();
    drive(1, 1, 0, 0, 0, 0, 0, 60, 100); tick();
    chk("s0_q", 32'(bus.Q), 50);
    chk("s0_atlow", 32'(bus.at_low), 0);

    // Inverted bounds: load parks at low, moves hold.
    drive(1, 0, 1, 50, 1, 0, 3, 200, 100); tick();
    chk("inv_load", 32'(bus.Q), 200);
    drive(1, 1, 0, 0, 0, 0, 3, 200, 100); tick();
    chk("inv_hold", 32'(bus.Q), 200);

`ifdef BOUNCE_COUNTER_RAMP_EN
    // Ramp grows by one per bounce, saturates, and clears on load.
    drive(1, 0, 1, 0, 1, 0, 2, 0, 20); tick();
    drive(1, 1, 0, 0, 0, 0, 2, 0, 20);
    for (int k = 1; k <= 4; k++) begin
      bounces = 0;
      budget  = 0;
      while (bounces == 0 && budget < 40) begin
        tick();
        budget++;
        if (bus.bounce_lo || bus.bounce_hi) bounces = 1;
      end
      chk("ramp_seen", 32'(bounces), 1);
      chk("ramp_step", 32'(bus.cur_step), (2 + k > 5) ? 5 : 2 + k);
    end
    drive(1, 0, 1, 10, 1, 0, 2, 0, 20); tick();
    chk("ramp_clr", 32'(bus.cur_step), 2);
`endif

    // Randomized traffic.
    lo_r = 10; hi_r = 900; st_r = 3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        lo_r = $urandom_range(0, 600);
        hi_r = $urandom_range(0, 1023);
      end
      if ($urandom_range(0, 7) == 0) st_r = $urandom_range(0, STEP_SAT);
      drive(($urandom_range(0, 99) == 0) ? 0 : 1,
            ($urandom_range(0, 3) != 0) ? 1 : 0,
            ($urandom_range(0, 39) == 0) ? 1 : 0,
            $urandom_range(0, 1023),
            $urandom_range(0, 1),
            (lo_r <= hi_r && $urandom_range(0, 9) == 0) ? 1 : 0,
            st_r, lo_r, hi_r);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
